mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multi-cycle main control FSM for the MIPS datapath. It sequences PC, instruction register, memory, register file, ALU operand muxes and the 16-to-32-bit immediate extender (sign or zero). One instruction executes over 3–5 states. Memory accesses stall on a ready handshake. The block sits between the instruction register's opcode field and every datapath control point; ALU function decode (funct field) lives in a separate ALU-control block driven by `alu_op`.

## Interface

**Parameters**
- `STATE_W`, default 4: state register width.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset.
- `opcode`, input, 6: instruction bits [31:26] from the IR. Sampled only in DECODE.
- `zero`, input, 1: ALU zero flag. Used only in BEQ.
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `pc_write`, output, 1: unconditional PC load.
- `pc_write_cond`, output, 1: PC load if `zero`.
- `i_or_d`, output, 1: memory address source. 0 = PC, 1 = ALUOut.
- `mem_read`, output, 1: memory read request.
- `mem_write`, output, 1: memory write request.
- `ir_write`, output, 1: IR load.
- `mem_to_reg`, output, 1: writeback source. 1 = MDR.
- `reg_dst`, output, 1: destination register. 1 = rd, 0 = rt.
- `reg_write`, output, 1: register file write.
- `alu_src_a`, output, 1: ALU A input. 0 = PC, 1 = A register.
- `alu_src_b`, output, 2: ALU B input. 00 = B register, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- `alu_op`, output, 2: 00 = add, 01 = subtract, 10 = funct decode, 11 = logical immediate.
- `pc_src`, output, 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ext_sel`, output, 1: extender mode. 0 = sign extend, 1 = zero extend.
- `illegal_op`, output, 1: one-cycle pulse when an undecodable opcode is detected.
- `state`, output, `STATE_W`: current state, for debug.

## Operation

**State encodings**
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- REX = 6, RWB = 7, BEQ = 8, ADDIEX = 9, IMMWB = 10, JUMP = 11, LOGEX = 12

**Opcodes decoded**
- R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- andi 001100 and ori 001101 only with the macro (see Configuration).

**Outputs**
- Moore-style: decoded combinationally from `state`, except that `mem_ready` gates the handshake signals listed below.
- Any output not listed for a state is 0.

**Per-state behaviour**
- **FETCH:** `mem_read` = 1, `alu_src_b` = 01. `ir_write` = `pc_write` = `mem_ready`. Stay until `mem_ready`, then go to DECODE.
- **DECODE:** `alu_src_b` = 11, `ext_sel` = 0 (branch target precompute).
  - lw/sw → MEMADR, R → REX, beq → BEQ, addi → ADDIEX, j → JUMP, andi/ori → LOGEX.
  - Any other opcode: `illegal_op` = 1, next state FETCH.
- **MEMADR:** `alu_src_a` = 1, `alu_src_b` = 10, `ext_sel` = 0. lw → MEMRD, sw → MEMWR. The opcode is latched in DECODE into an internal register; `opcode` is not re-sampled.
- **MEMRD:** `mem_read` = 1, `i_or_d` = 1. Stay until `mem_ready`, then MEMWB.
- **MEMWB:** `reg_write` = 1, `mem_to_reg` = 1, `reg_dst` = 0. Next FETCH.
- **MEMWR:** `mem_write` = 1, `i_or_d` = 1. Hold until `mem_ready`, then FETCH.
- **REX:** `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10. Next RWB.
- **RWB:** `reg_write` = 1, `reg_dst` = 1. Next FETCH.
- **BEQ:** `alu_src_a` = 1, `alu_op` = 01, `pc_write_cond` = 1, `pc_src` = 01. Next FETCH.
- **ADDIEX:** `alu_src_a` = 1, `alu_src_b` = 10, `ext_sel` = 0. Next IMMWB.
- **LOGEX:** `alu_src_a` = 1, `alu_src_b` = 10, `ext_sel` = 1, `alu_op` = 11. Next IMMWB.
- **IMMWB:** `reg_write` = 1, `reg_dst` = 0. Next FETCH.
- **JUMP:** `pc_write` = 1, `pc_src` = 10. Next FETCH.

**Robustness**
- Unused encodings (13–15) go to FETCH and pulse `illegal_op`.

## Timing

**Reset**
- `rst_n` is sampled low at a rising edge → `state` = FETCH after that edge; the latched opcode clears to 0.
- While in reset, outputs follow FETCH decoding.
- Reset mid-instruction aborts with no further `reg_write` or `mem_write`.

**Cycles with no stall**
- lw 5, sw 4, R-type 4, addi 4, andi/ori 4, beq 3, j 3.
- Each stall cycle (`mem_ready` = 0 in FETCH, MEMRD or MEMWR) adds exactly one cycle; all outputs are held stable during the stall.

**Handshake**
- `mem_read` and `mem_write` stay asserted until the cycle in which `mem_ready` = 1.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.

**Other**
- `illegal_op` is high for exactly one cycle.
- `opcode` must be stable only in DECODE.

## Configuration

**`MIPS_ZERO_EXT_IMM_EN`**
- **Defined:** andi/ori decode to LOGEX, which drives `ext_sel` = 1 and `alu_op` = 11.
- **Undefined:** the LOGEX state is not compiled in. andi/ori are illegal (`illegal_op` pulse, return to FETCH), and `ext_sel` is constant 0.

## Test plan

- **Reset:** `rst_n` = 0 for 2 cycles mid-REX → `state` = 0 after the next edge, `reg_write` never asserts, and FETCH outputs are `mem_read` = 1, `alu_src_b` = 01.
- **lw with stalls:** opcode 100011, `mem_ready` low 2 cycles in FETCH and 1 cycle in MEMRD → states 0,0,0,1,2,3,3,4,0 (8 cycles). `reg_write` and `mem_to_reg` are high only in state 4.
- **sw:** opcode 101011 with `mem_ready` = 1 → states 0,1,2,5,0. `mem_write` is high for 1 cycle and `reg_write` never asserts.
- **beq:** opcode 000100 → BEQ (8) asserts `pc_write_cond` = 1, `pc_src` = 01, `alu_op` = 01. DECODE shows `alu_src_b` = 11, `ext_sel` = 0.
- **addi then ori:** addi → state 9 with `ext_sel` = 0. ori → state 12 with `ext_sel` = 1 when the macro is defined; when it is undefined, a 1-cycle `illegal_op` pulse and return to 0.
- **Illegal and jump:** opcode 111111 → `illegal_op` = 1 in DECODE, next state 0. Opcode 000010 → JUMP (11) with `pc_write` = 1, `pc_src` = 10, then FETCH.

Source files
------------

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// master = controller side, slave = datapath/memory side.
// Carries opcode/flags/handshake inward and every datapath control point outward.
interface mips_mc_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src;
    logic               ext_sel;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, ext_sel, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_src, ext_sel, illegal_op, state
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 states per instruction; Moore outputs decoded from the state register.
// Backpressure: FETCH, MEMRD and MEMWR hold (outputs stable) until mem_ready.
// Optional macro MIPS_ZERO_EXT_IMM_EN adds andi/ori via the LOGEX state.
module mips_mc_control #(
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_mc_control_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 0,
        S_DECODE = 1,
        S_MEMADR = 2,
        S_MEMRD  = 3,
        S_MEMWB  = 4,
        S_MEMWR  = 5,
        S_REX    = 6,
        S_RWB    = 7,
        S_BEQ    = 8,
        S_ADDIEX = 9,
        S_IMMWB  = 10,
        S_JUMP   = 11
`ifdef MIPS_ZERO_EXT_IMM_EN
        ,
        S_LOGEX  = 12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_ZERO_EXT_IMM_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    state_t     state_q;
    state_t     state_d;
    state_t     cur;
    logic [5:0] op_q;

    // While reset is held the outputs decode as FETCH, so an aborted
    // instruction cannot issue a further register or memory write.
    assign cur       = rst_n ? state_q : S_FETCH;
    assign bus.state = state_q;

    // State register and opcode latch (opcode captured once, in DECODE).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
            end
        end
    end

    // Next-state and Moore output decode; mem_ready only gates the handshakes.
    always_comb begin
        state_d           = S_FETCH;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_src        = 2'b00;
        bus.ext_sel       = 1'b0;
        bus.illegal_op    = 1'b0;

        case (cur)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (sext(imm) << 2).
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_ZERO_EXT_IMM_EN
                    OP_ANDI, OP_ORI: state_d = S_LOGEX;
`endif
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                state_d      = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                state_d       = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_RWB;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                // The datapath qualifies pc_write_cond with the ALU zero flag.
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                state_d           = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_IMMWB;
            end
`ifdef MIPS_ZERO_EXT_IMM_EN
            S_LOGEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ext_sel   = 1'b1;
                bus.alu_op    = 2'b11;
                state_d       = S_IMMWB;
            end
`endif
            S_IMMWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
                state_d      = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH and flag the event.
                bus.illegal_op = 1'b1;
                state_d        = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle state/output checks per instruction class.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Every task starts and ends just after a rising edge with the FSM parked in FETCH.
module tb_mips_mc_control;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mips_mc_control_if #(.STATE_W(4)) bus ();

    mips_mc_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 6'b000000; bus.zero = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'b01 || bus.reg_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_init state=%0d mem_read=%b alu_src_b=%b reg_write=%b exp 0/1/01/0",
                     bus.state, bus.mem_read, bus.alu_src_b, bus.reg_write);
        end
        // Run an R-type into REX, then reset it.
        rst_n = 1'b1; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd6 || bus.alu_op !== 2'b10 || bus.alu_src_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_rex state=%0d alu_op=%b alu_src_a=%b exp 6/10/1", bus.state, bus.alu_op, bus.alu_src_a);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (bus.state !== 4'd0 || bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0 ||
                bus.mem_read !== 1'b1 || bus.alu_src_b !== 2'b01) begin
                failures++;
                $display("FAIL reset_abort cyc%0d state=%0d reg_write=%b mem_write=%b mem_read=%b alu_src_b=%b exp 0/0/0/1/01",
                         i, bus.state, bus.reg_write, bus.mem_write, bus.mem_read, bus.alu_src_b);
            end
        end
        rst_n = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.state !== 4'd0) begin
            failures++;
            $display("FAIL reset_release state=%0d exp 0", bus.state);
        end
    endtask

    task automatic test_lw_stall();
        int   es[9] = '{0, 0, 0, 1, 2, 3, 3, 4, 0};
        logic mr[9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
        bus.opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            bus.mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (bus.state !== es[i][3:0]) begin
                failures++;
                $display("FAIL lw_state cyc%0d got=%0d exp=%0d", i, bus.state, es[i]);
            end
            checks++;
            if (bus.reg_write !== (es[i] == 4) || bus.mem_to_reg !== (es[i] == 4)) begin
                failures++;
                $display("FAIL lw_wb cyc%0d reg_write=%b mem_to_reg=%b exp=%b", i, bus.reg_write, bus.mem_to_reg, es[i] == 4);
            end
            checks++;
            if (bus.ir_write !== (es[i] == 0 && mr[i]) || bus.mem_read !== (es[i] == 0 || es[i] == 3) ||
                bus.i_or_d !== (es[i] == 3)) begin
                failures++;
                $display("FAIL lw_mem cyc%0d ir_write=%b mem_read=%b i_or_d=%b", i, bus.ir_write, bus.mem_read, bus.i_or_d);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        int   es[5] = '{0, 1, 2, 5, 0};
        logic mr[5] = '{1, 1, 1, 1, 0};
        int   wr_cycles = 0;
        bus.opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = mr[i];
            @(negedge clk);
            if (bus.mem_write === 1'b1) wr_cycles++;
            checks++;
            if (bus.state !== es[i][3:0] || bus.reg_write !== 1'b0) begin
                failures++;
                $display("FAIL sw_state cyc%0d state=%0d reg_write=%b exp %0d/0", i, bus.state, bus.reg_write, es[i]);
            end
            if (es[i] == 2) begin
                checks++;
                if (bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10 || bus.ext_sel !== 1'b0) begin
                    failures++;
                    $display("FAIL sw_memadr alu_src_a=%b alu_src_b=%b ext_sel=%b exp 1/10/0", bus.alu_src_a, bus.alu_src_b, bus.ext_sel);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (wr_cycles != 1) begin
            failures++;
            $display("FAIL sw_write_count got=%0d exp=1", wr_cycles);
        end
    endtask

    task automatic test_beq();
        int   es[4] = '{0, 1, 8, 0};
        logic mr[4] = '{1, 1, 1, 0};
        bus.opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (bus.state !== es[i][3:0]) begin
                failures++;
                $display("FAIL beq_state cyc%0d got=%0d exp=%0d", i, bus.state, es[i]);
            end
            if (es[i] == 1) begin
                checks++;
                if (bus.alu_src_b !== 2'b11 || bus.ext_sel !== 1'b0 || bus.illegal_op !== 1'b0) begin
                    failures++;
                    $display("FAIL beq_decode alu_src_b=%b ext_sel=%b illegal_op=%b exp 11/0/0", bus.alu_src_b, bus.ext_sel, bus.illegal_op);
                end
            end
            if (es[i] == 8) begin
                checks++;
                if (bus.pc_write_cond !== 1'b1 || bus.pc_src !== 2'b01 || bus.alu_op !== 2'b01 || bus.pc_write !== 1'b0) begin
                    failures++;
                    $display("FAIL beq_exec pc_write_cond=%b pc_src=%b alu_op=%b pc_write=%b exp 1/01/01/0",
                             bus.pc_write_cond, bus.pc_src, bus.alu_op, bus.pc_write);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_ori();
        int   ea[5] = '{0, 1, 9, 10, 0};
        logic mr[5] = '{1, 1, 1, 1, 0};
`ifdef MIPS_ZERO_EXT_IMM_EN
        int   eo[5] = '{0, 1, 12, 10, 0};
        int   no = 5;
`else
        int   eo[5] = '{0, 1, 0, 0, 0};
        int   no = 3;
`endif
        bus.opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (bus.state !== ea[i][3:0] || bus.reg_write !== (ea[i] == 10)) begin
                failures++;
                $display("FAIL addi_state cyc%0d state=%0d reg_write=%b exp %0d", i, bus.state, bus.reg_write, ea[i]);
            end
            if (ea[i] == 9) begin
                checks++;
                if (bus.ext_sel !== 1'b0 || bus.alu_src_b !== 2'b10 || bus.alu_op !== 2'b00) begin
                    failures++;
                    $display("FAIL addi_exec ext_sel=%b alu_src_b=%b alu_op=%b exp 0/10/00", bus.ext_sel, bus.alu_src_b, bus.alu_op);
                end
            end
            @(posedge clk); #1;
        end
        bus.opcode = 6'b001101;
        for (int i = 0; i < no; i++) begin
            bus.mem_ready = (i == no - 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (bus.state !== eo[i][3:0] || bus.illegal_op !== (no == 3 && i == 1)) begin
                failures++;
                $display("FAIL ori_state cyc%0d state=%0d illegal_op=%b exp %0d/%b", i, bus.state, bus.illegal_op, eo[i], no == 3 && i == 1);
            end
            if (eo[i] == 12) begin
                checks++;
                if (bus.ext_sel !== 1'b1 || bus.alu_op !== 2'b11 || bus.alu_src_b !== 2'b10) begin
                    failures++;
                    $display("FAIL ori_exec ext_sel=%b alu_op=%b alu_src_b=%b exp 1/11/10", bus.ext_sel, bus.alu_op, bus.alu_src_b);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_jump();
        int   ej[4] = '{0, 1, 11, 0};
        bus.opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (bus.state !== ((i == 1) ? 4'd1 : 4'd0) || bus.illegal_op !== (i == 1)) begin
                failures++;
                $display("FAIL illegal cyc%0d state=%0d illegal_op=%b exp %0d/%b", i, bus.state, bus.illegal_op, i == 1, i == 1);
            end
            @(posedge clk); #1;
        end
        bus.opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (bus.state !== ej[i][3:0]) begin
                failures++;
                $display("FAIL jump_state cyc%0d got=%0d exp=%0d", i, bus.state, ej[i]);
            end
            if (ej[i] == 11) begin
                checks++;
                if (bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10 || bus.illegal_op !== 1'b0 || bus.reg_write !== 1'b0) begin
                    failures++;
                    $display("FAIL jump_exec pc_write=%b pc_src=%b illegal_op=%b reg_write=%b exp 1/10/0/0",
                             bus.pc_write, bus.pc_src, bus.illegal_op, bus.reg_write);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_sw();
        test_beq();
        test_addi_ori();
        test_illegal_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
